// File: rtl/d_trig_pkg.sv
// Shared defaults and next-state rule for the d_trig leaf flop.
`timescale 1ns/1ps
package d_trig_pkg;

  localparam bit INIT_VAL_DEF  = 1'b0;
  localparam bit RESET_VAL_DEF = 1'b1;

  // Reset dominates data when both are presented at the same edge.
  function automatic logic next_q(input logic r, input logic d, input logic rst_val);
    return r ? rst_val : d;
  endfunction

endpackage

// File: rtl/d_trig.sv
// D flip-flop, rising-edge C, synchronous active-high reset R, complementary output.
// Latency: D->Q exactly one rising edge; no handshake, so no backpressure.
`timescale 1ns/1ps
module d_trig
  import d_trig_pkg::*;
#(
  parameter bit INIT_VAL  = INIT_VAL_DEF,
  parameter bit RESET_VAL = RESET_VAL_DEF
) (
  input  logic C,
  input  logic R,
  input  logic D,
  output logic Q,
  output logic notQ
);

  // Power-up value comes from the declaration; R only ever loads RESET_VAL.
  logic q_reg = INIT_VAL;

  always_ff @(posedge C) begin
    q_reg <= next_q(R, D, RESET_VAL);
  end

  assign Q    = q_reg;
  assign notQ = ~q_reg;

endmodule

// File: tb/tb_d_trig.sv
// Directed-vector bench for d_trig: default and swapped INIT/RESET parameter instances.
`timescale 1ns/1ps
module tb_d_trig;

  logic C  = 1'b0;
  logic r1 = 1'b0, d1 = 1'b0;
  logic r2 = 1'b1, d2 = 1'b1;
  logic q1, nq1, q2, nq2;

  int n_chk  = 0;
  int n_pass = 0;
  int rise_cnt = 0;

  d_trig u_dut_def (
    .C    (C),
    .R    (r1),
    .D    (d1),
    .Q    (q1),
    .notQ (nq1)
  );

  d_trig #(.INIT_VAL(1'b1), .RESET_VAL(1'b0)) u_dut_swp (
    .C    (C),
    .R    (r2),
    .D    (d2),
    .Q    (q2),
    .notQ (nq2)
  );

  initial forever #5 C = ~C;

  always @(posedge C) rise_cnt++;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
  endtask

  task automatic at(input int t);
    #(t - $time);
  endtask

  // Mid-step sampler: complement relation and edge-only changes of Q.
  initial begin
    logic q1_prev, q2_prev;
    int   rise_prev;
    #0.5;
    q1_prev   = q1;
    q2_prev   = q2;
    rise_prev = rise_cnt;
    forever begin
      #1;
      chk("nq1_inv", nq1, ~q1);
      chk("nq2_inv", nq2, ~q2);
      if (q1 !== q1_prev) chk("q1_only_at_rise", rise_cnt != rise_prev, 1'b1);
      if (q2 !== q2_prev) chk("q2_only_at_rise", rise_cnt != rise_prev, 1'b1);
      q1_prev   = q1;
      q2_prev   = q2;
      rise_prev = rise_cnt;
    end
  end

  initial begin
    at(1);
    chk("init_q1", q1, 1'b0);
    chk("init_nq1", nq1, 1'b1);
    chk("init_q2", q2, 1'b1);
    chk("init_nq2", nq2, 1'b0);

    at(2);  r1 = 1'b1;
    at(3);  chk("no_async_rst_q1", q1, 1'b0);
    at(4);  r1 = 1'b0;
    at(6);
    chk("short_r_ignored_q1", q1, 1'b0);
    chk("short_r_ignored_nq1", nq1, 1'b1);
    chk("swp_rst_wins_q2", q2, 1'b0);
    chk("swp_rst_wins_nq2", nq2, 1'b1);
    at(7);  r2 = 1'b0;
    at(16); chk("swp_load_d_q2", q2, 1'b1);
    at(17); r2 = 1'b1;
    at(19); r2 = 1'b0;
    at(20); chk("swp_short_r_ignored_q2", q2, 1'b1);

    at(30); d1 = 1'b1;
    at(31); chk("no_comb_d_q1", q1, 1'b0);
    at(34); chk("before_edge_q1", q1, 1'b0);
    at(36);
    chk("after_edge_q1", q1, 1'b1);
    chk("after_edge_nq1", nq1, 1'b0);
    at(38); d1 = 1'b0;
    at(41); chk("falling_edge_q1", q1, 1'b1);
    at(42); d1 = 1'b1;

    at(44); r1 = 1'b1;
    at(46);
    r1 = 1'b0;
    chk("edge_rst_q1", q1, 1'b1);
    chk("edge_rst_nq1", nq1, 1'b0);
    at(50); d1 = 1'b0;
    at(56);
    chk("post_rst_load_q1", q1, 1'b0);
    chk("post_rst_load_nq1", nq1, 1'b1);
    at(60); d1 = 1'b1;
    at(66); chk("load_one_q1", q1, 1'b1);

    at(72); d1 = 1'b0; r1 = 1'b1;
    at(76);
    chk("rst_beats_d_q1", q1, 1'b1);
    chk("rst_beats_d_nq1", nq1, 1'b0);
    at(86); chk("rst_held_q1", q1, 1'b1);
    at(87); r1 = 1'b0;
    at(96);
    chk("first_free_edge_q1", q1, 1'b0);
    chk("first_free_edge_nq1", nq1, 1'b1);

    at(100); r2 = 1'b1; d2 = 1'b1;
    at(106);
    chk("swp_rst_again_q2", q2, 1'b0);
    chk("swp_rst_again_nq2", nq2, 1'b1);
    at(107); r2 = 1'b0;
    at(116);
    chk("swp_release_q2", q2, 1'b1);
    chk("swp_release_nq2", nq2, 1'b0);

    at(120);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
